controle_varredura: RTL and testbench

//  Sequences the radar sweep: steps the 3-bit servo position (consumed by the position->angle decoder)

---
 rtl/controle_varredura_pkg.sv | 27 ++
 rtl/contador_timer.sv | 23 ++
 rtl/controle_varredura.sv | 127 ++++++++++++
 tb/tb_controle_varredura.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_varredura_pkg.sv
// rtl/controle_varredura_pkg.sv - state codes, sweep limits and ping-pong step helper
package controle_varredura_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    POSICIONA    = 4'd1,
    MEDE         = 4'd2,
    AGUARDA      = 4'd3,
    ENVIA        = 4'd4,
    ESPERA_ENVIO = 4'd5,
    PROXIMO      = 4'd6
  } estado_t;

  localparam int         N_POSICOES = 8;
  localparam logic [2:0] POS_MAX    = 3'(N_POSICOES - 1);

  // Returns {direcao, posicao} for the next stop; the ends turn around without repeating.
  function automatic logic [3:0] proximo_passo(input logic dir, input logic [2:0] pos);
    logic [3:0] r;
    if (!dir && pos == POS_MAX)    r = {1'b1, POS_MAX - 3'd1};
    else if (dir && pos == 3'd0)   r = {1'b0, 3'd1};
    else if (!dir)                 r = {1'b0, pos + 3'd1};
    else                           r = {1'b1, pos - 3'd1};
    return r;
  endfunction

endpackage

// File: rtl/contador_timer.sv
// rtl/contador_timer.sv - shared cycle timer with sync clear, enable and terminal-count flag
module contador_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             limpa,
  input  logic             conta,
  input  logic [WIDTH-1:0] limite,
  output logic             fim
);

  logic [WIDTH-1:0] valor;

  always_ff @(posedge clock) begin
    if (!reset)     valor <= '0;
    else if (limpa) valor <= '0;
    else if (conta) valor <= valor + 1'b1;
  end

  assign fim = (valor == limite);

endmodule

// File: rtl/controle_varredura.sv
// rtl/controle_varredura.sv - radar sweep sequencer: servo stepping, settle, sonar trigger, tx handoff
module controle_varredura
  import controle_varredura_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 50_000_000,
  parameter int TIMEOUT_CYCLES = 3_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_medida,
  input  logic       fim_envio,
  output logic [2:0] posicao,
  output logic       medir,
  output logic       envia,
  output logic       erro_medida,
  output logic       direcao,
  output logic [3:0] db_estado
);

  localparam int MAX_CYC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] LIM_SETTLE  = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] LIM_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);

  estado_t       estado, prox;
  logic          limpa, conta, fim_timer;
  logic [TW-1:0] limite;
  logic          medir_d, envia_d, erro_d, dir_d;
  logic [2:0]    pos_d;
  logic [3:0]    passo;

  // One timer serves both waits; the limit follows whichever phase is active.
  assign limite = (estado == AGUARDA) ? LIM_TIMEOUT : LIM_SETTLE;
  assign passo  = proximo_passo(direcao, posicao);

  contador_timer #(.WIDTH(TW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .limpa  (limpa),
    .conta  (conta),
    .limite (limite),
    .fim    (fim_timer)
  );

  always_comb begin
    prox   = estado;
    limpa  = 1'b0;
    conta  = 1'b0;
    erro_d = erro_medida;
    pos_d  = posicao;
    dir_d  = direcao;
    case (estado)
      INICIAL: begin
        if (ligar) begin
          prox  = POSICIONA;
          limpa = 1'b1;
        end
      end
      POSICIONA: begin
        if (fim_timer) begin
          prox   = MEDE;
          erro_d = 1'b0;
        end else begin
          conta = 1'b1;
        end
      end
      MEDE: begin
        prox  = AGUARDA;
        limpa = 1'b1;
      end
      // A completion arriving on the timeout cycle still counts as a good measurement.
      AGUARDA: begin
        if (fim_medida) begin
          prox   = ENVIA;
          erro_d = 1'b0;
        end else if (fim_timer) begin
          prox   = ENVIA;
          erro_d = 1'b1;
        end else begin
          conta = 1'b1;
        end
      end
      ENVIA: prox = ESPERA_ENVIO;
      ESPERA_ENVIO: begin
        if (fim_envio) prox = PROXIMO;
      end
      PROXIMO: begin
        if (ligar) begin
          prox           = POSICIONA;
          limpa          = 1'b1;
          {dir_d, pos_d} = passo;
        end else begin
          prox  = INICIAL;
          pos_d = 3'd0;
          dir_d = 1'b0;
        end
      end
      default: prox = INICIAL;
    endcase
  end

  // Pulses are registered on state entry so they line up with MEDE/ENVIA in db_estado.
  assign medir_d = (prox == MEDE);
  assign envia_d = (prox == ENVIA);

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= INICIAL;
      posicao     <= 3'd0;
      direcao     <= 1'b0;
      medir       <= 1'b0;
      envia       <= 1'b0;
      erro_medida <= 1'b0;
    end else begin
      estado      <= prox;
      posicao     <= pos_d;
      direcao     <= dir_d;
      medir       <= medir_d;
      envia       <= envia_d;
      erro_medida <= erro_d;
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controle_varredura.sv
// tb/tb_controle_varredura.sv - randomized self-checking bench for controle_varredura
module tb_controle_varredura;

  localparam int S = 4;
  localparam int T = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ligar = 1'b0;
  logic       fim_medida = 1'b0;
  logic       fim_envio = 1'b0;
  logic [2:0] posicao;
  logic       medir, envia, erro_medida, direcao;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_medir = 0;
  int n_envia = 0;
  int idx = 0;

  controle_varredura #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clock       (clock),
    .reset       (reset),
    .ligar       (ligar),
    .fim_medida  (fim_medida),
    .fim_envio   (fim_envio),
    .posicao     (posicao),
    .medir       (medir),
    .envia       (envia),
    .erro_medida (erro_medida),
    .direcao     (direcao),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (medir) n_medir <= n_medir + 1;
    if (envia) n_envia <= n_envia + 1;
  end

  // Reference sweep: measurement i of a pass visits 0..7..1 then repeats with period 14.
  function automatic logic [2:0] ref_pos(input int i);
    int p;
    p = i % 14;
    if (p <= 7) return 3'(p);
    return 3'(14 - p);
  endfunction

  function automatic logic ref_dir(input int i);
    int p;
    p = i % 14;
    return (p >= 8) || (p == 0 && i > 0);
  endfunction

  // fim_medida driven in AGUARDA cycle d (1..T) ends the wait; otherwise the timeout does.
  function automatic int ref_lat_envia(input int d);
    return (d >= 1 && d <= T) ? d + 1 : T + 1;
  endfunction

  function automatic logic ref_erro(input int d);
    return !(d >= 1 && d <= T);
  endfunction

  task automatic wait_envia(input int d, output int c, output logic er, output logic [2:0] p,
                            output logic xm);
    c = -1; er = 1'bx; p = 3'bx; xm = 1'b0;
    for (int k = 1; k <= 3 * T; k++) begin
      @(negedge clock);
      if (medir) xm = 1'b1;
      if (envia) begin
        c = k; er = erro_medida; p = posicao; fim_medida = 1'b0;
        return;
      end
      fim_medida = (k == d);
    end
    fim_medida = 1'b0;
  endtask

  task automatic wait_medir(input int f, input logic ruido, output int c, output logic [2:0] p,
                            output logic dr, output logic er, output logic xe);
    c = -1; p = 3'bx; dr = 1'bx; er = 1'bx; xe = 1'b0;
    for (int k = 1; k <= 4 * S + 20; k++) begin
      @(negedge clock);
      if (envia) xe = 1'b1;
      if (medir) begin
        c = k; p = posicao; dr = direcao; er = erro_medida;
        fim_envio = 1'b0; fim_medida = 1'b0;
        return;
      end
      fim_envio  = (k == f);
      fim_medida = ruido && ((k == 1) || (k == f + 3));
    end
    fim_envio = 1'b0; fim_medida = 1'b0;
  endtask

  task automatic wait_inicial(input int f, output int c, output logic [2:0] p, output logic dr);
    c = -1; p = 3'bx; dr = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (db_estado == 4'd0) begin
        c = k; p = posicao; dr = direcao; fim_envio = 1'b0;
        return;
      end
      fim_envio = (k == f);
    end
    fim_envio = 1'b0;
  endtask

  // One full position with inline checks against the reference sweep.
  task automatic test_step(input string nm, input int d, input int f);
    int c; logic er, dr, xm, xe; logic [2:0] p;
    wait_envia(d, c, er, p, xm);
    checks++;
    if (c != ref_lat_envia(d) || er !== ref_erro(d) || p !== ref_pos(idx) || xm !== 1'b0) begin
      errors++;
      $display("FAIL %s_envia idx=%0d d=%0d got lat=%0d erro=%b pos=%0d xmedir=%b want lat=%0d erro=%b pos=%0d xmedir=0",
               nm, idx, d, c, er, p, xm, ref_lat_envia(d), ref_erro(d), ref_pos(idx));
    end
    wait_medir(f, 1'b1, c, p, dr, er, xe);
    idx++;
    checks++;
    if (c != f + 2 + S || p !== ref_pos(idx) || dr !== ref_dir(idx) || er !== 1'b0 || xe !== 1'b0) begin
      errors++;
      $display("FAIL %s_medir idx=%0d got lat=%0d pos=%0d dir=%b erro=%b xenvia=%b want lat=%0d pos=%0d dir=%b erro=0 xenvia=0",
               nm, idx, c, p, dr, er, xe, f + 2 + S, ref_pos(idx), ref_dir(idx));
    end
  endtask

  task automatic test_reset();
    int c; logic er, dr, xe; logic [2:0] p;
    reset = 1'b0; ligar = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (db_estado !== 4'd0 || posicao !== 3'd0 || direcao !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got db=%0d pos=%0d dir=%b want 0 0 0", db_estado, posicao, direcao);
    end
    checks++;
    if (medir !== 1'b0 || envia !== 1'b0 || erro_medida !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got medir=%b envia=%b erro=%b want 0 0 0", medir, envia, erro_medida);
    end
    reset = 1'b1;
    wait_medir(0, 1'b0, c, p, dr, er, xe);
    checks++;
    if (c != S + 1) begin
      errors++;
      $display("FAIL first_medir_latency got %0d want %0d", c, S + 1);
    end
    checks++;
    if (db_estado !== 4'd2 || p !== 3'd0 || dr !== 1'b0) begin
      errors++;
      $display("FAIL first_medir_state got db=%0d pos=%0d dir=%b want 2 0 0", db_estado, p, dr);
    end
    idx = 0;
  endtask

  task automatic test_sweep();
    int start;
    start = n_medir;
    for (int i = 0; i < 15; i++) test_step("sweep", $urandom_range(1, T - 1), $urandom_range(1, 4));
    checks++;
    if (n_medir - start != 15 || posicao !== 3'd1) begin
      errors++;
      $display("FAIL sweep_round_trip got pulses=%0d pos=%0d want 15 1", n_medir - start, posicao);
    end
  endtask

  task automatic test_timeout();
    test_step("timeout", 0, $urandom_range(1, 4));
  endtask

  task automatic test_timeout_edge();
    test_step("timeout_edge", T, $urandom_range(1, 4));
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) test_step("b2b", $urandom_range(1, T + 2), $urandom_range(1, 4));
  endtask

  task automatic test_ligar_drop();
    int c, start, f; logic er, dr, xm; logic [2:0] p;
    while (!(ref_pos(idx) == 3'd3 && ref_dir(idx) == 1'b1)) test_step("drop_walk", 2, 1);
    ligar = 1'b0;
    wait_envia(3, c, er, p, xm);
    checks++;
    if (c != 4 || p !== 3'd3 || er !== 1'b0) begin
      errors++;
      $display("FAIL drop_envia got lat=%0d pos=%0d erro=%b want 4 3 0", c, p, er);
    end
    f = $urandom_range(1, 4);
    wait_inicial(f, c, p, dr);
    checks++;
    if (c != f + 2 || p !== 3'd0 || dr !== 1'b0) begin
      errors++;
      $display("FAIL drop_inicial got lat=%0d pos=%0d dir=%b want %0d 0 0", c, p, dr, f + 2);
    end
    start = n_medir;
    repeat (8) @(negedge clock);
    checks++;
    if (db_estado !== 4'd0 || n_medir != start) begin
      errors++;
      $display("FAIL drop_idle got db=%0d medir_pulses=%0d want 0 0", db_estado, n_medir - start);
    end
  endtask

  task automatic test_reset_mid();
    int c, sm, se; logic er, dr, xe, xm; logic [2:0] p;
    ligar = 1'b1;
    wait_medir(0, 1'b0, c, p, dr, er, xe);
    checks++;
    if (c != S + 1 || p !== 3'd0) begin
      errors++;
      $display("FAIL restart_medir got lat=%0d pos=%0d want %0d 0", c, p, S + 1);
    end
    idx = 0;
    for (int i = 0; i < 5; i++) test_step("mid_walk", $urandom_range(1, T), 1);
    wait_envia(1, c, er, p, xm);
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd5 || posicao !== 3'd5) begin
      errors++;
      $display("FAIL mid_espera got db=%0d pos=%0d want 5 5", db_estado, posicao);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd0 || posicao !== 3'd0 || direcao !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state got db=%0d pos=%0d dir=%b want 0 0 0", db_estado, posicao, direcao);
    end
    checks++;
    if (medir !== 1'b0 || envia !== 1'b0 || erro_medida !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_pulses got medir=%b envia=%b erro=%b want 0 0 0", medir, envia, erro_medida);
    end
    sm = n_medir; se = n_envia;
    reset = 1'b1; ligar = 1'b0; fim_envio = 1'b1;
    @(negedge clock);
    fim_envio = 1'b0;
    repeat (8) @(negedge clock);
    checks++;
    if (db_estado !== 4'd0 || n_medir != sm || n_envia != se) begin
      errors++;
      $display("FAIL mid_reset_idle got db=%0d medir=%0d envia=%0d want 0 0 0",
               db_estado, n_medir - sm, n_envia - se);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_ligar_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
